y_sample_buffer: RTL and testbench

//  Downstream stage of the Y address arbiter. Captures memory read data for each
//  Y address it issues and buffers it in a FIFO for the compute datapath.

---
 rtl/y_pkg.sv | 23 ++
 rtl/y_sample_buffer_if.sv | 33 +++
 rtl/y_sample_fifo.sv | 54 +++++
 rtl/y_sample_buffer.sv | 130 +++++++++++++
 tb/tb_y_sample_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y_pkg.sv
// Shared constants and types for the Y sample buffer slice.
// Address constants match the Y address arbiter's addressY encoding.
// sample_t is the FIFO entry layout {data, last} at the default sample width.
package y_pkg;

  localparam int ADDR_W   = 11;
  localparam int SAMPLE_W = 8;

  localparam logic [ADDR_W-1:0] Y_ADDR_IDLE  = 11'h3F;
  localparam logic [ADDR_W-1:0] Y_ADDR_FIRST = 11'h40;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2
  } rel_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                last;
  } sample_t;

endpackage

// File: rtl/y_sample_buffer_if.sv
// Bundle between the Y address arbiter / memory side and the sample buffer.
// master: arbiter, memory and consumer side; slave: the sample buffer.
// Consumer backpressure is out_valid/out_ready; the arbiter side uses EOF/sig.
interface y_sample_buffer_if
  import y_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] addressY;
  logic              addr_valid;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              EOF;
  logic              sig;
  logic [4:0]        frame_cnt;
  logic              ovf_err;
  logic              seq_err;

  modport master (
    output addressY, addr_valid, mem_data, out_ready,
    input  out_data, out_last, out_valid, EOF, sig, frame_cnt, ovf_err, seq_err
  );

  modport slave (
    input  addressY, addr_valid, mem_data, out_ready,
    output out_data, out_last, out_valid, EOF, sig, frame_cnt, ovf_err, seq_err
  );

endinterface

// File: rtl/y_sample_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a synchronous flush.
// Latency: a pushed entry is visible at the head the next cycle (no bypass).
// Backpressure: a push while full is dropped unless a pop happens that cycle.
module y_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the full-case push lands in, so it is accepted.
  assign do_push = push & (~full | do_pop);

  // Pointer update; flush empties the queue without touching storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; no reset needed since empty masks the read port.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/y_sample_buffer.sv
// Captures Y memory read data per issued address into a FIFO and runs frame release.
// Latency: capture MEM_LAT cycles after the strobe, head visible one cycle later.
// Backpressure: out_ready pops the FIFO; EOF holds the arbiter until the frame drains.
module y_sample_buffer
  import y_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int MEM_LAT     = 1,
  parameter int FRAME_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              CompStart,
  y_sample_buffer_if.slave  bus
);

  localparam int              CNT_W    = $clog2(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

  logic [MEM_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0]  pipe_addr [MEM_LAT];
  logic [CNT_W-1:0]   word_cnt;
  logic [ADDR_W-1:0]  exp_addr;
  rel_state_t         state;
  rel_state_t         state_nxt;
  logic [4:0]         frame_cnt_q;
  logic               ovf_q;
  logic               seq_q;
  logic               eof;
  logic               is_last;
  logic               cap;
  logic               cap_last;
  logic               pop_eff;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W:0]    rd_dat;

  assign eof      = (state != RUN);
  // Captures arriving during EOF or a flush are dropped silently.
  assign cap      = pipe_vld[MEM_LAT-1] & ~eof & ~CompStart;
  assign is_last  = (word_cnt == LAST_IDX);
  assign cap_last = cap & is_last;
  assign pop_eff  = bus.out_ready & ~fifo_empty;
  assign exp_addr = Y_ADDR_FIRST + ADDR_W'(word_cnt);

  // Delay the strobe and address to line up with the memory read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_addr[i] <= '0;
    end else if (CompStart) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0]  <= bus.addr_valid;
      pipe_addr[0] <= bus.addressY;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Word position in the frame, sticky error flags and released-frame count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_cnt    <= '0;
      ovf_q       <= 1'b0;
      seq_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (CompStart) begin
      word_cnt <= '0;
      ovf_q    <= 1'b0;
      seq_q    <= 1'b0;
    end else begin
      if (cap) begin
        word_cnt <= is_last ? '0 : word_cnt + CNT_W'(1);
        if (pipe_addr[MEM_LAT-1] != exp_addr) seq_q <= 1'b1;
        if (fifo_full && !pop_eff) ovf_q <= 1'b1;
      end
      if (state == REL) frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  // Release FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Release FSM next state: hold after the final capture until the FIFO drains.
  always_comb begin
    state_nxt = state;
    if (CompStart) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (cap_last) state_nxt = HOLD;
        HOLD:    if (fifo_empty) state_nxt = REL;
        REL:     state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  y_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .flush  (CompStart),
    .push   (cap),
    .pop    (bus.out_ready),
    .wr_dat ({bus.mem_data, is_last}),
    .rd_dat (rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.out_data  = rd_dat[DATA_W:1];
  assign bus.out_last  = rd_dat[0];
  assign bus.out_valid = ~fifo_empty;
  assign bus.EOF       = eof;
  assign bus.sig       = (state == REL);
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.seq_err   = seq_q;

endmodule

// File: tb/tb_y_sample_buffer.sv
// Bench for y_sample_buffer: instance A (4-word frames) is checked every cycle
// against a queue-based model; instance B (32-word frames) exercises FIFO fill,
// overflow and full-with-pop using directed literal expectations.
module tb_y_sample_buffer;
  import y_pkg::*;

  localparam int FW_A    = 4;
  localparam int DEPTH   = 16;
  localparam int LAT_A   = 1;

  logic clock = 1'b0;
  logic rst_a, rst_b, comp_a, comp_b;

  always #5 clock = ~clock;

  y_sample_buffer_if #(.DATA_W(8)) ifa ();
  y_sample_buffer_if #(.DATA_W(8)) ifb ();

  y_sample_buffer #(.DATA_W(8), .DEPTH(DEPTH), .MEM_LAT(LAT_A), .FRAME_WORDS(FW_A)) dut_a (
    .clock(clock), .reset(rst_a), .CompStart(comp_a), .bus(ifa));

  y_sample_buffer #(.DATA_W(8), .DEPTH(DEPTH), .MEM_LAT(1), .FRAME_WORDS(32)) dut_b (
    .clock(clock), .reset(rst_b), .CompStart(comp_b), .bus(ifb));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural model of instance A ----------------
  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } pend_t;

  pend_t   pend[$];
  sample_t m_q[$];
  int      m_word, m_frames, m_cyc;
  bit      m_eof, m_sig, m_ovf, m_seq;
  bit      cmp_en = 0;

  initial begin : model_a
    forever begin
      @(posedge clock or negedge rst_a);
      if (!rst_a) begin
        pend.delete(); m_q.delete();
        m_word = 0; m_frames = 0; m_cyc = 0;
        m_eof = 0; m_sig = 0; m_ovf = 0; m_seq = 0;
      end else begin : upd
        int                qs;
        bit                popd, capd, last, n_eof, n_sig;
        logic [ADDR_W-1:0] caddr;
        sample_t           s;
        m_cyc++;
        if (comp_a) begin
          pend.delete(); m_q.delete();
          m_word = 0; m_eof = 0; m_sig = 0; m_ovf = 0; m_seq = 0;
        end else begin
          qs    = m_q.size();
          popd  = ifa.out_ready && (qs > 0);
          capd  = 0;
          caddr = '0;
          if (pend.size() > 0 && pend[0].due == m_cyc) begin
            caddr = pend[0].addr;
            void'(pend.pop_front());
            capd = !m_eof;
          end
          n_eof = m_eof;
          n_sig = 0;
          if (m_sig) begin
            m_frames++;
            n_eof = 0;
          end else if (m_eof && qs == 0) begin
            n_sig = 1;
          end
          if (popd) void'(m_q.pop_front());
          if (capd) begin
            last = (m_word == FW_A - 1);
            if (caddr != ADDR_W'(32'h40 + m_word)) m_seq = 1;
            s.data = ifa.mem_data;
            s.last = last;
            if (m_q.size() >= DEPTH) m_ovf = 1;
            else m_q.push_back(s);
            m_word = last ? 0 : m_word + 1;
            if (last) n_eof = 1;
          end
          m_eof = n_eof;
          m_sig = n_sig;
          if (ifa.addr_valid) pend.push_back('{m_cyc + LAT_A, ifa.addressY});
        end
      end
    end
  end

  // ---------------- monitors and per-cycle compare ----------------
  sample_t    pop_a[$];
  logic [7:0] pop_b[$];
  int         sig_cnt_a = 0;
  bit         eof_seen_a = 0;

  initial begin : compare
    sample_t ps;
    forever begin
      @(negedge clock);
      if (ifa.sig === 1'b1) sig_cnt_a++;
      if (ifa.EOF === 1'b1) eof_seen_a = 1;
      if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
        ps.data = ifa.out_data;
        ps.last = ifa.out_last;
        pop_a.push_back(ps);
      end
      if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) pop_b.push_back(ifb.out_data);
      if (cmp_en) begin
        chk("a_out_valid", ifa.out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
          chk("a_out_data", ifa.out_data, m_q[0].data);
          chk("a_out_last", ifa.out_last, m_q[0].last);
        end else begin
          chk("a_out_data_empty", ifa.out_data, 0);
          chk("a_out_last_empty", ifa.out_last, 0);
        end
        chk("a_eof", ifa.EOF, m_eof);
        chk("a_sig", ifa.sig, m_sig);
        chk("a_frame_cnt", ifa.frame_cnt, m_frames % 32);
        chk("a_ovf_err", ifa.ovf_err, m_ovf);
        chk("a_seq_err", ifa.seq_err, m_seq);
      end
    end
  end

  // One strobe every three cycles, data returned the cycle after the strobe.
  task automatic a_strobe(input logic [ADDR_W-1:0] addr, input logic [7:0] dat);
    ifa.addr_valid = 1'b1;
    ifa.addressY   = addr;
    tick();
    ifa.addr_valid = 1'b0;
    ifa.mem_data   = dat;
    tick();
    ifa.mem_data   = 8'h00;
    tick();
  endtask

  task automatic a_frame(input logic [ADDR_W-1:0] ad[4], input logic [7:0] d[4]);
    for (int i = 0; i < 4; i++) a_strobe(ad[i], d[i]);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : main
    logic [7:0]        d[4];
    logic [ADDR_W-1:0] seq_ad[4];
    logic [ADDR_W-1:0] bad_ad[4];
    int                base;

    rst_a = 1'b0; rst_b = 1'b0; comp_a = 1'b0; comp_b = 1'b0;
    ifa.addressY = '0; ifa.addr_valid = 1'b0; ifa.mem_data = '0; ifa.out_ready = 1'b0;
    ifb.addressY = '0; ifb.addr_valid = 1'b0; ifb.mem_data = '0; ifb.out_ready = 1'b0;
    seq_ad = '{11'h40, 11'h41, 11'h42, 11'h43};
    bad_ad = '{11'h40, 11'h41, 11'h45, 11'h43};
    repeat (2) tick();

    // Reset state
    chk("rst_a_valid", ifa.out_valid, 0);
    chk("rst_a_eof",   ifa.EOF, 0);
    chk("rst_a_frame", ifa.frame_cnt, 0);
    chk("rst_b_valid", ifb.out_valid, 0);
    chk("rst_b_data",  ifb.out_data, 0);
    chk("rst_b_ovf",   ifb.ovf_err, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    cmp_en = 1;

    // T1: one clean 4-word frame with out_ready held high
    ifa.out_ready = 1'b1;
    pop_a.delete(); base = sig_cnt_a; eof_seen_a = 0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_frame(seq_ad, d);
    repeat (6) tick();
    chk("t1_pops", pop_a.size(), 4);
    for (int i = 0; i < pop_a.size() && i < 4; i++) begin
      chk("t1_data", pop_a[i].data, d[i]);
      chk("t1_last", pop_a[i].last, (i == 3));
    end
    chk("t1_eof_seen",   eof_seen_a, 1);
    chk("t1_sig_pulses", sig_cnt_a - base, 1);
    chk("t1_frame_cnt",  ifa.frame_cnt, 1);
    chk("t1_eof_low",    ifa.EOF, 0);

    // T4: address 0x45 at word 2, data still delivered
    pop_a.delete();
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    a_frame(bad_ad, d);
    repeat (6) tick();
    chk("t4_seq_err", ifa.seq_err, 1);
    chk("t4_pops",    pop_a.size(), 4);
    if (pop_a.size() > 2) chk("t4_data_word2", pop_a[2].data, 8'hA3);
    chk("t4_frame_cnt", ifa.frame_cnt, 2);
    chk("t4_ovf_err",   ifa.ovf_err, 0);

    // T5: CompStart after 2 of 4 words with out_ready low
    ifa.out_ready = 1'b0;
    a_strobe(11'h40, 8'h55);
    a_strobe(11'h41, 8'h66);
    comp_a = 1'b1;
    tick();
    comp_a = 1'b0;
    chk("t5_flush_valid", ifa.out_valid, 0);
    chk("t5_flush_eof",   ifa.EOF, 0);
    chk("t5_flush_seq",   ifa.seq_err, 0);
    chk("t5_flush_ovf",   ifa.ovf_err, 0);
    chk("t5_flush_frame", ifa.frame_cnt, 2);
    ifa.out_ready = 1'b1;
    pop_a.delete(); base = sig_cnt_a;
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    a_frame(seq_ad, d);
    repeat (6) tick();
    chk("t5_sig_pulses", sig_cnt_a - base, 1);
    chk("t5_frame_cnt",  ifa.frame_cnt, 3);
    chk("t5_pops",       pop_a.size(), 4);
    chk("t5_seq_err",    ifa.seq_err, 0);

    // T6: frame held in HOLD, stray strobe ignored, async reset mid-HOLD
    ifa.out_ready = 1'b0;
    d = '{8'h91, 8'h92, 8'h93, 8'h94};
    a_frame(seq_ad, d);
    repeat (2) tick();
    chk("t6_eof_hold", ifa.EOF, 1);
    a_strobe(11'h7F, 8'hFF);
    chk("t6_seq_ignored", ifa.seq_err, 0);
    chk("t6_valid_hold",  ifa.out_valid, 1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("t6_rst_valid", ifa.out_valid, 0);
    chk("t6_rst_data",  ifa.out_data, 0);
    chk("t6_rst_last",  ifa.out_last, 0);
    chk("t6_rst_eof",   ifa.EOF, 0);
    chk("t6_rst_sig",   ifa.sig, 0);
    chk("t6_rst_frame", ifa.frame_cnt, 0);
    chk("t6_rst_ovf",   ifa.ovf_err, 0);
    chk("t6_rst_seq",   ifa.seq_err, 0);
    tick();
    rst_a = 1'b1;
    tick();
    ifa.out_ready = 1'b1;
    pop_a.delete(); base = sig_cnt_a;
    d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    a_frame(seq_ad, d);
    repeat (6) tick();
    chk("t6_pops", pop_a.size(), 4);
    if (pop_a.size() == 4) begin
      chk("t6_first_data", pop_a[0].data, 8'hC1);
      chk("t6_last_flag",  pop_a[3].last, 1);
    end
    chk("t6_frame_cnt",  ifa.frame_cnt, 1);
    chk("t6_sig_pulses", sig_cnt_a - base, 1);
    chk("t6_seq_err",    ifa.seq_err, 0);

    // T2 (instance B): 17 back-to-back captures with out_ready low
    ifb.out_ready = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      ifb.addr_valid = (k < 17);
      ifb.addressY   = ADDR_W'(32'h40 + k);
      ifb.mem_data   = (k > 0) ? 8'(32'hB0 + k - 1) : 8'h00;
      tick();
    end
    ifb.addr_valid = 1'b0; ifb.mem_data = 8'h00;
    tick();
    chk("t2_ovf_err",   ifb.ovf_err, 1);
    chk("t2_out_valid", ifb.out_valid, 1);
    chk("t2_seq_err",   ifb.seq_err, 0);
    chk("t2_head",      ifb.out_data, 8'hB0);
    pop_b.delete();
    ifb.out_ready = 1'b1;
    repeat (20) tick();
    ifb.out_ready = 1'b0;
    chk("t2_retained", pop_b.size(), 16);
    for (int i = 0; i < pop_b.size() && i < 16; i++) chk("t2_order", pop_b[i], 8'(32'hB0 + i));
    comp_b = 1'b1;
    tick();
    comp_b = 1'b0;
    chk("t2_flush_ovf", ifb.ovf_err, 0);

    // T3 (instance B): full FIFO with capture and pop in the same cycle
    for (int k = 0; k <= 16; k++) begin
      ifb.addr_valid = (k < 16);
      ifb.addressY   = ADDR_W'(32'h40 + k);
      ifb.mem_data   = (k > 0) ? 8'(32'hE0 + k - 1) : 8'h00;
      tick();
    end
    ifb.addr_valid = 1'b0; ifb.mem_data = 8'h00;
    tick();
    chk("t3_full_no_ovf", ifb.ovf_err, 0);
    pop_b.delete();
    ifb.addr_valid = 1'b1;
    ifb.addressY   = 11'h50;
    tick();
    ifb.addr_valid = 1'b0;
    ifb.mem_data   = 8'h5A;
    ifb.out_ready  = 1'b1;
    tick();
    ifb.out_ready  = 1'b0;
    ifb.mem_data   = 8'h00;
    chk("t3_push_pop_ovf", ifb.ovf_err, 0);
    ifb.out_ready = 1'b1;
    repeat (20) tick();
    ifb.out_ready = 1'b0;
    chk("t3_pops", pop_b.size(), 17);
    for (int i = 0; i < pop_b.size() && i < 16; i++) chk("t3_order", pop_b[i], 8'(32'hE0 + i));
    if (pop_b.size() == 17) chk("t3_new_tail", pop_b[16], 8'h5A);
    chk("t3_seq_err", ifb.seq_err, 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
